// File: rtl/dft_frame_packer.sv
// dft_frame_packer: turns a per-frame config plus a raw I/Q stream into
// sop/eop framed traffic for the mixed-radix DFT core. It forces an idle gap
// after each frame and rejects lengths the core cannot run.
module dft_frame_packer #(
  parameter int DW         = 18,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 16,
  parameter int FCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [11:0]       cfg_pts,
  input  logic              cfg_inverse,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_real,
  input  logic [DW-1:0]     s_imag,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sop,
  output logic              m_eop,
  output logic [DW-1:0]     m_real,
  output logic [DW-1:0]     m_imag,
  output logic [5:0]        m_size,
  output logic              m_inverse,
  output logic              cfg_err,
  output logic [FCNT_W-1:0] frames_done
);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  // Last value of the gap counter before returning to IDLE.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Maps a point count onto the core's size code; bit 6 flags a supported length.
  function automatic logic [6:0] size_lookup(input logic [11:0] pts);
    logic       ok;
    logic [5:0] code;
    ok   = 1'b1;
    code = 6'd0;
    case (pts)
      12'd12:   code = 6'd0;
      12'd24:   code = 6'd1;
      12'd36:   code = 6'd2;
      12'd48:   code = 6'd3;
      12'd60:   code = 6'd4;
      12'd72:   code = 6'd5;
      12'd96:   code = 6'd6;
      12'd108:  code = 6'd7;
      12'd120:  code = 6'd8;
      12'd144:  code = 6'd9;
      12'd180:  code = 6'd10;
      12'd192:  code = 6'd11;
      12'd216:  code = 6'd12;
      12'd240:  code = 6'd13;
      12'd288:  code = 6'd14;
      12'd300:  code = 6'd15;
      12'd324:  code = 6'd16;
      12'd360:  code = 6'd17;
      12'd384:  code = 6'd18;
      12'd432:  code = 6'd19;
      12'd480:  code = 6'd20;
      12'd540:  code = 6'd21;
      12'd576:  code = 6'd22;
      12'd600:  code = 6'd23;
      12'd648:  code = 6'd24;
      12'd720:  code = 6'd25;
      12'd768:  code = 6'd26;
      12'd864:  code = 6'd27;
      12'd900:  code = 6'd28;
      12'd960:  code = 6'd29;
      12'd972:  code = 6'd30;
      12'd1080: code = 6'd31;
      12'd1152: code = 6'd32;
      12'd1200: code = 6'd33;
      default:  ok   = 1'b0;
    endcase
    return {ok, code};
  endfunction

  state_t             state, state_nxt;
  logic [6:0]         lk;
  logic               cfg_ok;
  logic               cfg_fire, s_fire, m_fire, eop_fire;
  logic [11:0]        pts_q;
  logic [CNT_W-1:0]   smp_cnt, gap_cnt;
  logic               last_smp;
  // Set once the eop sample sits in the output register; blocks further input.
  logic               eop_pend;

  assign lk       = size_lookup(cfg_pts);
  assign cfg_ok   = lk[6];
  assign cfg_fire = cfg_valid && cfg_ready;
  assign s_fire   = s_valid && s_ready;
  assign m_fire   = m_valid && m_ready;
  assign eop_fire = m_fire && m_eop;
  assign last_smp = (smp_cnt == (CNT_W'(pts_q) - CNT_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake readies; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_ok) state_nxt = STREAM;
      end
      STREAM: begin
        s_ready = !eop_pend && (!m_valid || m_ready);
        if (eop_fire) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Frame config latch; an aborted handshake leaves the old config in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pts_q     <= '0;
      m_size    <= '0;
      m_inverse <= 1'b0;
    end else if (cfg_fire && cfg_ok && !abort) begin
      pts_q     <= cfg_pts;
      m_size    <= lk[5:0];
      m_inverse <= cfg_inverse;
    end
  end

  // One-cycle pulse for a rejected length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_fire && !cfg_ok && !abort;
  end

  // Gap counter runs only while staying in GAP, restarting at 0 on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  gap_cnt <= '0;
    else if (state == GAP && state_nxt == GAP)   gap_cnt <= gap_cnt + CNT_W'(1);
    else                                         gap_cnt <= '0;
  end

  // Single output register with sample numbering; holds its contents while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_sop    <= 1'b0;
      m_eop    <= 1'b0;
      m_real   <= '0;
      m_imag   <= '0;
      smp_cnt  <= '0;
      eop_pend <= 1'b0;
    end else if (abort) begin
      m_valid  <= 1'b0;
      m_sop    <= 1'b0;
      m_eop    <= 1'b0;
      smp_cnt  <= '0;
      eop_pend <= 1'b0;
    end else begin
      if (s_fire) begin
        m_valid <= 1'b1;
        m_real  <= s_real;
        m_imag  <= s_imag;
        m_sop   <= (smp_cnt == '0);
        m_eop   <= last_smp;
        if (last_smp) begin
          eop_pend <= 1'b1;
          smp_cnt  <= '0;
        end else begin
          smp_cnt  <= smp_cnt + CNT_W'(1);
        end
      end else if (m_fire) begin
        m_valid <= 1'b0;
      end
      if (eop_fire) eop_pend <= 1'b0;
    end
  end

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  frames_done <= '0;
    else if (eop_fire && !abort) frames_done <= frames_done + FCNT_W'(1);
  end

endmodule

// File: tb/tb_dft_frame_packer.sv
// Directed bench for dft_frame_packer: one instance with the default 16-cycle
// gap, and a second with no gap for the back-to-back timing case.
module tb_dft_frame_packer;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a (GAP_CYCLES = 16)
  logic          cfg_valid, cfg_inverse, abort_a, s_valid, m_ready;
  logic [11:0]   cfg_pts;
  logic [DW-1:0] s_real, s_imag;
  logic          cfg_ready, s_ready, m_valid, m_sop, m_eop, m_inverse, cfg_err;
  logic [DW-1:0] m_real, m_imag;
  logic [5:0]    m_size;
  logic [7:0]    frames_done;

  // instance b (GAP_CYCLES = 0)
  logic          cfg_valid_b, cfg_inverse_b, abort_b, s_valid_b, m_ready_b;
  logic [11:0]   cfg_pts_b;
  logic [DW-1:0] s_real_b, s_imag_b;
  logic          cfg_ready_b, s_ready_b, m_valid_b, m_sop_b, m_eop_b, m_inverse_b, cfg_err_b;
  logic [DW-1:0] m_real_b, m_imag_b;
  logic [5:0]    m_size_b;
  logic [7:0]    frames_done_b;

  dft_frame_packer #(.DW(DW), .CNT_W(16), .GAP_CYCLES(16), .FCNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pts(cfg_pts), .cfg_inverse(cfg_inverse),
    .abort(abort_a),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
    .m_real(m_real), .m_imag(m_imag), .m_size(m_size), .m_inverse(m_inverse),
    .cfg_err(cfg_err), .frames_done(frames_done)
  );

  dft_frame_packer #(.DW(DW), .CNT_W(16), .GAP_CYCLES(0), .FCNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_pts(cfg_pts_b), .cfg_inverse(cfg_inverse_b),
    .abort(abort_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_real(s_real_b), .s_imag(s_imag_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_sop(m_sop_b), .m_eop(m_eop_b),
    .m_real(m_real_b), .m_imag(m_imag_b), .m_size(m_size_b), .m_inverse(m_inverse_b),
    .cfg_err(cfg_err_b), .frames_done(frames_done_b)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_fd = 8'd0;

  function automatic logic [DW-1:0] re(input int k);
    return DW'(k * 7 + 5);
  endfunction

  function automatic logic [DW-1:0] im(input int k);
    return DW'(200000 - k * 3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one config for a single cycle; returns just after the handshake edge.
  task automatic do_cfg(input int pts, input bit inv);
    s_valid     = 1'b0;
    cfg_valid   = 1'b1;
    cfg_pts     = 12'(pts);
    cfg_inverse = inv;
    #1;
    chk("cfg_ready_idle", cfg_ready, 1);
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Stream samples; the model numbers outputs by its own accept count.
  task automatic run_frame(input int pts, input bit toggle, input int abort_at);
    int sent, rcv, n;
    bit ph, sf, mf;
    sent = 0; rcv = 0; n = 0; ph = 1'b0;
    while (rcv < pts && n < 10000) begin
      if (abort_at >= 0 && sent == abort_at) break;
      s_valid = 1'b1;
      s_real  = re(sent);
      s_imag  = im(sent);
      m_ready = toggle ? ph : 1'b1;
      ph      = !ph;
      #1;
      if (sent == pts) chk("s_ready_after_eop", s_ready, 0);
      if (m_valid) begin
        chk("m_real", m_real, re(rcv));
        chk("m_imag", m_imag, im(rcv));
        chk("m_sop", m_sop, (rcv == 0));
        chk("m_eop", m_eop, (rcv == pts - 1));
      end
      sf = s_valid && s_ready;
      mf = m_valid && m_ready;
      if (mf) rcv++;
      if (sf) sent++;
      cyc();
      n++;
    end
    if (abort_at < 0) chk("frame_complete", rcv, pts);
  endtask

  // After eop accept: count, then the gap length measured via cfg_ready.
  task automatic finish_frame(input int gap);
    int g;
    bit bad;
    s_valid = 1'b1;
    m_ready = 1'b1;
    exp_fd  = exp_fd + 8'd1;
    chk("frames_done", frames_done, exp_fd);
    chk("m_valid_after_eop", m_valid, 0);
    g = 0; bad = 1'b0;
    while (!cfg_ready && g < 100) begin
      if (s_ready) bad = 1'b1;
      g++;
      cyc();
    end
    chk("gap_len", g, gap);
    chk("gap_s_ready", bad, 0);
    s_valid = 1'b0;
  endtask

  initial begin
    int kb, eop_cyc, sop2_cyc, nsop;
    cfg_valid = 0; cfg_inverse = 0; cfg_pts = '0; abort_a = 0;
    s_valid = 0; s_real = '0; s_imag = '0; m_ready = 1;
    cfg_valid_b = 0; cfg_inverse_b = 0; cfg_pts_b = '0; abort_b = 0;
    s_valid_b = 0; s_real_b = '0; s_imag_b = '0; m_ready_b = 1;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_sop", m_sop, 0);
    chk("rst_m_eop", m_eop, 0);
    chk("rst_m_size", m_size, 0);
    chk("rst_m_inverse", m_inverse, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_m_real", m_real, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // 12-point forward frame, free-flowing output
    do_cfg(12, 1'b0);
    chk("t1_m_size", m_size, 0);
    chk("t1_m_inverse", m_inverse, 0);
    chk("t1_cfg_ready_stream", cfg_ready, 0);
    run_frame(12, 1'b0, -1);
    finish_frame(16);

    // unsupported length, then 96 points
    do_cfg(99, 1'b0);
    s_valid = 1'b1;
    #1;
    chk("t3_cfg_err_pulse", cfg_err, 1);
    chk("t3_still_idle", cfg_ready, 1);
    chk("t3_s_ready_idle", s_ready, 0);
    cyc();
    chk("t3_cfg_err_clear", cfg_err, 0);
    do_cfg(96, 1'b0);
    chk("t3_m_size", m_size, 6);
    run_frame(96, 1'b0, -1);
    finish_frame(16);

    // 48 points aborted after 20 accepted samples
    do_cfg(48, 1'b0);
    chk("t4_m_size", m_size, 3);
    run_frame(48, 1'b0, 20);
    abort_a = 1'b1; s_valid = 1'b1; s_real = re(20); s_imag = im(20); m_ready = 1'b1;
    cyc();
    abort_a = 1'b0; s_valid = 1'b0;
    #1;
    chk("t4_abort_m_valid", m_valid, 0);
    chk("t4_abort_m_eop", m_eop, 0);
    chk("t4_abort_idle", cfg_ready, 1);
    chk("t4_abort_frames_done", frames_done, exp_fd);
    // abort wins over a simultaneous config: size stays at the 48-point code
    cfg_valid = 1'b1; cfg_pts = 12'd12; abort_a = 1'b1;
    cyc();
    cfg_valid = 1'b0; abort_a = 1'b0;
    #1;
    chk("t4_abort_cfg_size", m_size, 3);
    chk("t4_abort_cfg_idle", cfg_ready, 1);
    do_cfg(48, 1'b0);
    run_frame(48, 1'b0, -1);
    finish_frame(16);

    // 1200-point inverse with output stalls every other cycle
    do_cfg(1200, 1'b1);
    chk("t2_m_size", m_size, 33);
    chk("t2_m_inverse", m_inverse, 1);
    run_frame(1200, 1'b1, -1);
    finish_frame(16);

    // 256 frames of 12 points: counter crosses 255 -> 0
    for (int f = 0; f < 256; f++) begin
      do_cfg(12, 1'b0);
      run_frame(12, 1'b0, -1);
      finish_frame(16);
    end

    // zero-gap instance: config held valid, so frame 2 starts as soon as IDLE.
    // Cycle index c lies between edge c and edge c+1; eop accepted in cycle c
    // means the accept edge is c+1, and sop must show 2 edges later.
    cfg_valid_b = 1'b1; cfg_pts_b = 12'd24; m_ready_b = 1'b1; s_valid_b = 1'b1;
    kb = 0; eop_cyc = -1; sop2_cyc = -1; nsop = 0;
    for (int c = 0; c < 200 && sop2_cyc < 0; c++) begin
      s_real_b = re(kb % 24);
      s_imag_b = im(kb % 24);
      #1;
      if (m_valid_b && m_sop_b) begin
        nsop++;
        if (nsop == 2) begin
          sop2_cyc = c;
          chk("t5_sop2_real", m_real_b, re(0));
          chk("t5_sop2_size", m_size_b, 1);
        end
      end
      if (m_valid_b && m_ready_b && m_eop_b && eop_cyc < 0) eop_cyc = c;
      if (s_valid_b && s_ready_b) kb++;
      cyc();
    end
    chk("t5_sop_after_eop", sop2_cyc - (eop_cyc + 1), 2);
    chk("t5_frames_done", frames_done_b, 1);
    cfg_valid_b = 1'b0; s_valid_b = 1'b0;

    // async reset in the middle of a stalled frame
    do_cfg(48, 1'b1);
    s_valid = 1'b1; s_real = re(0); s_imag = im(0); m_ready = 1'b0;
    cyc();
    cyc();
    #2;
    chk("ar_pre_m_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_m_valid", m_valid, 0);
    chk("ar_cfg_ready", cfg_ready, 1);
    chk("ar_m_size", m_size, 0);
    chk("ar_m_inverse", m_inverse, 0);
    chk("ar_frames_done", frames_done, 0);
    chk("ar_m_sop", m_sop, 0);
    s_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("ar_post_idle", cfg_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
